// File: rtl/am_iq_modulator_pkg.sv
// Shared constants for the AM I/Q modulator: CORDIC arctangent table,
// gain-compensation constant and the control state encoding.
package am_mod_pkg;

  localparam int ANGLE_W    = 16;
  localparam int Z_W        = 17;
  localparam int GAIN_MUL   = 311;
  localparam int GAIN_SHIFT = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREP   = 2'd1,
    ST_ROTATE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  // atan(2^-i) in units where 65536 = 2*pi
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      4'd10:   atan_lut = 16'd10;
      4'd11:   atan_lut = 16'd5;
      4'd12:   atan_lut = 16'd3;
      4'd13:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/am_iq_modulator_if.sv
// Sample-in / I-Q-out bundle of the AM I/Q modulator, with status flags.
interface am_iq_modulator_if #(
  parameter int PHASE_W = 24,
  parameter int DW      = 12
);
  logic signed [DW-1:0]      audio_in;
  logic                      audio_valid;
  logic        [PHASE_W-1:0] phase_inc;
  logic        [7:0]         mod_depth;
  logic        [DW-1:0]      carrier_level;
  logic signed [DW-1:0]      I_out;
  logic signed [DW-1:0]      Q_out;
  logic                      out_valid;
  logic                      busy;
  logic                      overrun;
  logic                      clip;

  modport master (
    output audio_in, audio_valid, phase_inc, mod_depth, carrier_level,
    input  I_out, Q_out, out_valid, busy, overrun, clip
  );

  modport slave (
    input  audio_in, audio_valid, phase_inc, mod_depth, carrier_level,
    output I_out, Q_out, out_valid, busy, overrun, clip
  );
endinterface

// File: rtl/am_iq_modulator_cordic_rot_seq.sv
// Sequential rotation-mode CORDIC: quadrant fold on start, then one
// micro-rotation per clock; done is high during the final iteration.
module cordic_rot_seq
  import am_mod_pkg::*;
#(
  parameter int XW   = 15,
  parameter int ITER = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [XW-1:0]  x_init,
  input  logic [ANGLE_W-1:0]    angle,
  output logic                  done,
  output logic signed [XW-1:0]  x_res,
  output logic signed [XW-1:0]  y_res
);
  logic signed [XW-1:0]  x_reg, y_reg;
  logic signed [Z_W-1:0] z_reg;
  logic [3:0]            iter_reg;
  logic                  run_reg;

  logic                  fold;
  logic [ANGLE_W-1:0]    angle_f;
  logic signed [XW-1:0]  x_sh, y_sh;
  logic signed [Z_W-1:0] atan_ext;

  // Angles in the left half-plane are rotated by 180 deg up front so the
  // residual stays within the +-90 deg CORDIC convergence range.
  assign fold     = angle[ANGLE_W-1] ^ angle[ANGLE_W-2];
  assign angle_f  = fold ? angle + 16'h8000 : angle;
  assign x_sh     = x_reg >>> iter_reg;
  assign y_sh     = y_reg >>> iter_reg;
  assign atan_ext = {1'b0, atan_lut(iter_reg)};
  assign done     = run_reg && (iter_reg == 4'(ITER - 1));
  assign x_res    = x_reg;
  assign y_res    = y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg    <= '0;
      y_reg    <= '0;
      z_reg    <= '0;
      iter_reg <= '0;
      run_reg  <= 1'b0;
    end else if (start) begin
      x_reg    <= fold ? -x_init : x_init;
      y_reg    <= '0;
      z_reg    <= {angle_f[ANGLE_W-1], angle_f};
      iter_reg <= '0;
      run_reg  <= 1'b1;
    end else if (run_reg) begin
      if (z_reg[Z_W-1]) begin
        x_reg <= x_reg + y_sh;
        y_reg <= y_reg - x_sh;
        z_reg <= z_reg + atan_ext;
      end else begin
        x_reg <= x_reg - y_sh;
        y_reg <= y_reg + x_sh;
        z_reg <= z_reg - atan_ext;
      end
      iter_reg <= iter_reg + 4'd1;
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/am_iq_modulator.sv
// AM I/Q modulator: builds the envelope carrier + depth*audio, advances the
// NCO and rotates the envelope by the NCO phase to give signed I/Q.
module am_iq_modulator
  import am_mod_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int ITER    = 12,
  parameter int DW      = 12
) (
  input  logic           clk,
  input  logic           rst,
  am_iq_modulator_if.slave bus
);
  localparam int XW = DW + 3;
  localparam int EW = 24;
  localparam logic signed [EW-1:0] ENV_MAX = EW'((1 << (DW - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_POS = XW'((1 << (DW - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_NEG = -SAT_POS;

  state_t                 state_reg, state_next;
  logic [PHASE_W-1:0]     acc_reg;
  logic [ANGLE_W-1:0]     theta_reg;
  logic [DW-2:0]          env_reg;
  logic signed [DW-1:0]   i_reg, q_reg;
  logic                   out_valid_reg, overrun_reg, clip_reg;

  logic                   accept, drop, busy, start, done;
  logic signed [EW-1:0]   audio_ext, depth_ext, carrier_ext, prod, env_full;
  logic                   env_lo, env_hi;
  logic [DW-2:0]          env_sat;
  logic [EW-1:0]          gain_prod;
  logic signed [XW-1:0]   x_init, x_res, y_res;
  logic signed [XW-1:0]   res [2];
  logic signed [DW-1:0]   sat [2];
  logic [1:0]             hit;

  // Envelope at full width so negative or overlarge values can be detected.
  assign audio_ext   = {{(EW-DW){bus.audio_in[DW-1]}}, bus.audio_in};
  assign depth_ext   = {{(EW-8){1'b0}}, bus.mod_depth};
  assign carrier_ext = {{(EW-DW){1'b0}}, bus.carrier_level};
  assign prod        = audio_ext * depth_ext;
  assign env_full    = carrier_ext + (prod >>> 7);
  assign env_lo      = env_full[EW-1];
  assign env_hi      = !env_lo && (env_full > ENV_MAX);
  assign env_sat     = env_lo ? '0 : (env_hi ? '1 : env_full[DW-2:0]);

  // Pre-scale by ~1/K so the CORDIC gain restores the envelope amplitude.
  assign gain_prod = {{(EW-DW+1){1'b0}}, env_reg} * EW'(GAIN_MUL);
  assign x_init    = XW'(gain_prod >> GAIN_SHIFT);

  cordic_rot_seq #(.XW(XW), .ITER(ITER)) u_cordic (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_init (x_init),
    .angle  (theta_reg),
    .done   (done),
    .x_res  (x_res),
    .y_res  (y_res)
  );

  assign res[0] = x_res;
  assign res[1] = y_res;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_sat
    assign hit[gi] = (res[gi] > SAT_POS) || (res[gi] < SAT_NEG);
    assign sat[gi] = (res[gi] > SAT_POS) ? SAT_POS[DW-1:0] :
                     (res[gi] < SAT_NEG) ? SAT_NEG[DW-1:0] : res[gi][DW-1:0];
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg == ST_PREP) || (state_reg == ST_ROTATE);
    accept     = bus.audio_valid && !busy;
    drop       = bus.audio_valid && busy;
    start      = (state_reg == ST_PREP);
    unique case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_PREP;
      ST_PREP:   state_next = ST_ROTATE;
      ST_ROTATE: if (done) state_next = ST_OUT;
      ST_OUT:    state_next = accept ? ST_PREP : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      theta_reg     <= '0;
      env_reg       <= '0;
      i_reg         <= '0;
      q_reg         <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      clip_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_reg == ST_OUT);
      if (accept) begin
        env_reg   <= env_sat;
        theta_reg <= acc_reg[PHASE_W-1 -: ANGLE_W];
        acc_reg   <= acc_reg + bus.phase_inc;
        if (env_lo || env_hi) clip_reg <= 1'b1;
      end
      if (drop) overrun_reg <= 1'b1;
      if (state_reg == ST_OUT) begin
        i_reg <= sat[0];
        q_reg <= sat[1];
        if (|hit) clip_reg <= 1'b1;
      end
    end
  end

  assign bus.I_out     = i_reg;
  assign bus.Q_out     = q_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun_reg;
  assign bus.clip      = clip_reg;

endmodule

// File: tb/tb_am_iq_modulator.sv
// Randomised scoreboard bench for am_iq_modulator against an ideal
// floating-point AM/NCO reference (env * cos/sin of the NCO angle).
`timescale 1ns/1ps
module tb_am_iq_modulator;
  localparam int PHASE_W = 24;
  localparam int ITER    = 12;
  localparam int DW      = 12;
  localparam real PI     = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  am_iq_modulator_if #(.PHASE_W(PHASE_W), .DW(DW)) bus ();

  am_iq_modulator #(.PHASE_W(PHASE_W), .ITER(ITER), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    real i_exp;
    real q_exp;
    real tol;
    int  cyc;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int unsigned model_phase = 0;
  logic        model_overrun = 1'b0;
  logic        model_clip    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input real exp, input real tol);
    real diff;
    vectors++;
    diff = real'(act) - exp;
    if (diff < 0.0) diff = -diff;
    if (diff > tol) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0.2f +- %0.2f", name, act, exp, tol);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required no output", cyc);
        end else begin
          e = sb.pop_front();
          check_int("latency", cyc - e.cyc, ITER + 3);
          check_near("I_out", int'(bus.I_out), e.i_exp, e.tol);
          check_near("Q_out", int'(bus.Q_out), e.q_exp, e.tol);
          check_int("overrun", int'(bus.overrun), int'(model_overrun));
          check_int("clip", int'(bus.clip), int'(model_clip));
          $display("out cyc=%0d I=%0d Q=%0d exp=(%0.1f,%0.1f)", cyc, bus.I_out, bus.Q_out, e.i_exp, e.q_exp);
        end
      end
    end
  end

  // Drive one strobe at the current negedge; returns one negedge later.
  task automatic send(input int audio, input int depth, input int carrier,
                      input int unsigned inc, input bit accepted);
    int   env;
    int   angle;
    real  ang;
    exp_t e;
    bus.audio_in      = DW'(audio);
    bus.mod_depth     = 8'(depth);
    bus.carrier_level = DW'(carrier);
    bus.phase_inc     = PHASE_W'(inc);
    bus.audio_valid   = 1'b1;
    if (accepted) begin
      env = carrier + ((audio * depth) >>> 7);
      if (env < 0) begin
        env = 0;
        model_clip = 1'b1;
      end else if (env > 2047) begin
        env = 2047;
        model_clip = 1'b1;
      end
      angle   = int'(model_phase >> 8) & 16'hFFFF;
      ang     = 2.0 * PI * real'(angle) / 65536.0;
      e.i_exp = real'(env) * $cos(ang);
      e.q_exp = real'(env) * $sin(ang);
      // 3 LSB magnitude, angle error of 10 units, plus integer rounding slack.
      e.tol   = 5.0 + real'(env) * 2.0 * PI * 10.0 / 65536.0;
      e.cyc   = cyc;
      sb.push_back(e);
      model_phase = (model_phase + inc) & 32'h00FF_FFFF;
      $display("in  cyc=%0d audio=%0d depth=%0d carrier=%0d env=%0d angle=%0d", cyc, audio, depth, carrier, env, angle);
    end else begin
      model_overrun = 1'b1;
      $display("in  cyc=%0d audio=%0d dropped (busy)", cyc, audio);
    end
    @(negedge clk);
    bus.audio_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    model_phase   = 0;
    model_overrun = 1'b0;
    model_clip    = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    check_int({tag, "_I"}, int'(bus.I_out), 0);
    check_int({tag, "_Q"}, int'(bus.Q_out), 0);
    check_int({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check_int({tag, "_busy"}, int'(bus.busy), 0);
    check_int({tag, "_overrun"}, int'(bus.overrun), 0);
    check_int({tag, "_clip"}, int'(bus.clip), 0);
  endtask

  initial begin
    int busy_cnt;
    int gap;
    int waited;
    bus.audio_in      = '0;
    bus.audio_valid   = 1'b0;
    bus.phase_inc     = '0;
    bus.mod_depth     = '0;
    bus.carrier_level = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    do_reset();
    check_idle_state("reset");

    // Pure carrier at phase 0, and the busy window length.
    send(int'($urandom_range(0, 1000)) - 500, 0, 1000, 0, 1'b1);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    check_int("busy_cycles", busy_cnt, ITER + 1);

    // Quarter-turn NCO steps.
    for (int k = 0; k < 4; k++) begin
      send(0, 0, 1000, 32'h0040_0000, 1'b1);
      idle(19);
    end

    // Random traffic, including back-to-back acceptance in OUT.
    for (int k = 0; k < 24; k++) begin
      send(int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 200)),
           int'($urandom_range(700, 1200)), $urandom & 32'h00FF_FFFF, 1'b1);
      gap = (k % 3 == 0) ? ITER + 2 : int'($urandom_range(ITER + 2, ITER + 8));
      idle(gap - 1);
    end
    idle(4);

    // Envelope saturation high, then negative envelope clamped to zero.
    send(2047, 128, 2000, $urandom & 32'h00FF_FFFF, 1'b1);
    idle(19);
    check_int("clip_after_high", int'(bus.clip), 1);
    send(-1000, 128, 0, $urandom & 32'h00FF_FFFF, 1'b1);
    idle(19);

    // Sticky flags cleared only by reset.
    do_reset();
    check_idle_state("reset2");

    // Strobe while busy is dropped and does not advance the NCO.
    send(0, 0, 1000, 32'h0040_0000, 1'b1);
    idle(2);
    send(0, 0, 1000, 32'h0040_0000, 1'b0);
    idle(19);
    check_int("overrun_sticky", int'(bus.overrun), 1);
    send(0, 0, 1000, 32'h0040_0000, 1'b1);
    idle(19);

    // Reset during ROTATE aborts the sample; next sample restarts at phase 0.
    send(0, 0, 1000, 32'h0020_0000, 1'b1);
    idle(5);
    do_reset();
    idle(20);
    check_idle_state("abort");
    send(0, 0, 1000, 32'h0020_0000, 1'b1);
    idle(19);

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d outstanding samples, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/am_iq_modulator.md
Name: am_iq_modulator

Overview:
- Transmit-side counterpart of the AM demodulator. The demodulator computes magnitude sqrt(I²+Q²); this block takes audio samples, forms the AM envelope (carrier + depth·audio), and rotates it by an NCO phase to produce signed 12-bit I/Q.
- Implemented as a sequential CORDIC in rotation mode, one iteration per clock, with a valid/busy handshake.
- Sits between the audio/decimation path and the upconverter/DAC feed.

Parameters:
- PHASE_W, 24, phase accumulator width; the top 16 bits are the CORDIC angle, where 65536 = 2π.
- ITER, 12, number of CORDIC iterations; legal range 8..14.
- DW, 12, audio and I/Q sample width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- audio_in  in  DW  signed audio sample.
- audio_valid  in  1  one-cycle strobe qualifying audio_in.
- phase_inc  in  PHASE_W  NCO tuning word; sampled when a sample is accepted.
- mod_depth  in  8  unsigned modulation depth; 128 = 100 %.
- carrier_level  in  DW  unsigned carrier amplitude, 0..2047.
- I_out  out  DW  signed in-phase output; held between updates.
- Q_out  out  DW  signed quadrature output; held between updates.
- out_valid  out  1  one-cycle strobe, high when new I/Q values are presented.
- busy  out  1  high while a sample is in flight (states PREP, ROTATE).
- overrun  out  1  sticky; set when a strobe arrives while busy. Cleared only by rst.
- clip  out  1  sticky; set on envelope or output saturation. Cleared only by rst.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; I_out, Q_out, out_valid, busy, overrun, clip = 0; phase accumulator = 0. Reset aborts any in-flight sample; no out_valid is produced for it.
- States: IDLE, PREP, ROTATE, OUT.
  - A sample is accepted when audio_valid=1 in IDLE or OUT.
  - IDLE/OUT → PREP on acceptance; OUT → IDLE otherwise.
  - PREP → ROTATE after one cycle.
  - ROTATE runs iterations i = 0..ITER-1, one per clock, then → OUT.
- Accept cycle:
  - env = carrier_level + ((audio_in · mod_depth) >>> 7), computed at full width (≥22 bits, signed).
  - env is saturated to 0..2047; clip is set if saturation occurred.
  - Latch the current phase accumulator as theta, then accumulator += phase_inc (modulo 2^PHASE_W).
  - The first sample therefore uses phase 0.
- PREP:
  - Gain compensation: x0 = (env · 311) >> 9 (≈ env/1.6468); y0 = 0.
  - Angle = theta[PHASE_W-1 -: 16].
  - Quadrant fold: if the top two angle bits are 01 or 10, negate x0 and add 32768 to the angle, so the residual lies in ±90°.
  - Internal x/y width is DW+3 bits signed; z is 17 bits signed.
- ROTATE, iteration i:
  - d = sign(z).
  - x' = x − d·(y >>> i); y' = y + d·(x >>> i); z' = z − d·ATAN[i].
- OUT:
  - Saturate x and y to ±2047 (set clip if hit), register them to I_out/Q_out, and assert out_valid for exactly one cycle.
  - busy = 0 in this state.
- Latency: out_valid rises ITER+3 clocks after the accepting edge. Throughput is one sample per ITER+2 clocks (back-to-back acceptance in OUT is allowed).
- audio_valid while busy: the sample is dropped, overrun is set, and the phase accumulator does not advance.
- Output accuracy: magnitude error ≤ ±3 LSB; angle error ≤ 2·ATAN[ITER-1] units.
- mod_depth=0 gives a pure carrier. Negative envelope clamps to 0, so I=Q=0.

Decomposition:
- Package am_mod_pkg holds:
  - ATAN table (16-bit units): 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1;
  - the gain-compensation constant 311 and its shift of 9;
  - the state enum.
- One natural sub-module: cordic_rot_seq, containing the fold, the iteration registers and the iteration counter, with start/done handshake. The envelope logic, NCO and flags stay in the top level.

Test Plan:
- carrier_level=1000, mod_depth=0, phase_inc=0, one strobe → after 15 clocks out_valid=1, I_out=1000±3, Q_out=0±3; busy high for 13 cycles.
- carrier_level=1000, mod_depth=0, phase_inc=2^22, 4 strobes spaced 20 clocks apart → (I,Q) ≈ (1000,0), (0,1000), (−1000,0), (0,−1000), each ±3.
- carrier_level=2000, mod_depth=128, audio_in=2047 → env clamps to 2047; |I|≤2047; clip=1.
- carrier_level=0, mod_depth=128, audio_in=−1000 → I_out=0, Q_out=0; clip=1.
- Strobe, then a second strobe 3 clocks later → exactly one out_valid; overrun=1; the next valid sample still uses phase = 1·phase_inc.
- rst asserted during ROTATE → no out_valid; I/Q=0; the next sample uses phase 0 and completes normally.
